// File: rtl/counter_check_pkg.sv
// Shared types, default sizing and helpers for the counter stream checker.
package counter_check_pkg;

  typedef enum logic [1:0] {IDLE, SEEK, LOCKED} state_e;

  localparam int CNT_LSB    = 1;
  localparam int CNT_W      = 10;
  localparam int LOCK_COUNT = 4;
  localparam int ERR_W      = 16;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/counter_stream_checker_if.sv
// Producer-word input and monitor result bundle for counter_stream_checker.
interface counter_stream_checker_if #(
  parameter int CNT_W = 10,
  parameter int ERR_W = 16
);
  logic [31:0]      data_in;
  logic             valid;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [ERR_W-1:0] flag_rises;
  logic [CNT_W-1:0] last_cnt;

  modport master (
    output data_in, valid,
    input  locked, err_pulse, err_count, flag_rises, last_cnt
  );

  modport slave (
    input  data_in, valid,
    output locked, err_pulse, err_count, flag_rises, last_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// W-bit event counter that saturates at all-ones.
module sat_counter
  import counter_check_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [31:0] MAX_VAL = 32'((64'd1 << W) - 64'd1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     count <= '0;
    else if (en) count <= W'(sat_inc(32'(count), MAX_VAL));
  end

endmodule

// File: rtl/counter_stream_checker.sv
// Locks onto a +1 counter field in a producer word, reports breaks and counts flag rises.
module counter_stream_checker
  import counter_check_pkg::*;
#(
  parameter int CNT_LSB    = counter_check_pkg::CNT_LSB,
  parameter int CNT_W      = counter_check_pkg::CNT_W,
  parameter int LOCK_COUNT = counter_check_pkg::LOCK_COUNT,
  parameter int ERR_W      = counter_check_pkg::ERR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  counter_stream_checker_if.slave  bus
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  cnt_t             expected_q, expected_d;
  cnt_t             last_cnt_q, last_cnt_d;
  logic             prev_flag_q, prev_flag_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_en, rise_en;

  cnt_t field;
  logic flag;
  logic match;

  assign field = bus.data_in[CNT_LSB +: CNT_W];
  assign flag  = bus.data_in[0];
  assign match = (field == expected_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      run_q       <= '0;
      expected_q  <= '0;
      last_cnt_q  <= '0;
      prev_flag_q <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      expected_q  <= expected_d;
      last_cnt_q  <= last_cnt_d;
      prev_flag_q <= prev_flag_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    expected_d  = expected_q;
    last_cnt_d  = last_cnt_q;
    prev_flag_d = prev_flag_q;
    err_pulse_d = 1'b0;
    err_en      = 1'b0;
    rise_en     = 1'b0;

    if (bus.valid) begin
      last_cnt_d  = field;
      expected_d  = field + cnt_t'(1);
      prev_flag_d = flag;

      unique case (state_q)
        IDLE: begin
          // First sample only establishes the reference; no error or edge is possible yet.
          state_d = SEEK;
          run_d   = '0;
        end
        SEEK: begin
          rise_en = !prev_flag_q && flag;
          if (!match) begin
            run_d = '0;
          end else if (run_q + RUN_W'(1) == RUN_W'(LOCK_COUNT)) begin
            state_d = LOCKED;
            run_d   = '0;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end
        LOCKED: begin
          rise_en = !prev_flag_q && flag;
          if (!match) begin
            err_pulse_d = 1'b1;
            err_en      = 1'b1;
            state_d     = SEEK;
            run_d       = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  sat_counter #(.W(ERR_W)) u_err_count (
    .clk   (clk),
    .rst   (rst),
    .en    (err_en),
    .count (bus.err_count)
  );

  sat_counter #(.W(ERR_W)) u_flag_rises (
    .clk   (clk),
    .rst   (rst),
    .en    (rise_en),
    .count (bus.flag_rises)
  );

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_pulse = err_pulse_q;
  assign bus.last_cnt  = last_cnt_q;

endmodule

// File: tb/tb_counter_stream_checker.sv
// Randomised and directed bench for counter_stream_checker against a behavioural reference.
module tb_counter_stream_checker;

  localparam int LSB  = 1;
  localparam int CW   = 10;
  localparam int LC   = 4;
  localparam int EW   = 16;
  localparam int MODV = 1 << CW;
  localparam int EMAX = (1 << EW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  counter_stream_checker_if #(.CNT_W(CW), .ERR_W(EW)) bus ();

  counter_stream_checker #(
    .CNT_LSB    (LSB),
    .CNT_W      (CW),
    .LOCK_COUNT (LC),
    .ERR_W      (EW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests  = 0;
  int fails  = 0;
  int pulses = 0;

  // Reference: what the monitor must report, from the stream rules alone.
  bit m_started, m_locked, m_errp, m_prev;
  int m_streak, m_exp, m_last, m_err, m_rises;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin : model
    int  f;
    bit  fl;
    if (rst) begin
      m_started = 0; m_locked = 0; m_errp = 0; m_prev = 0;
      m_streak = 0; m_exp = 0; m_last = 0; m_err = 0; m_rises = 0;
    end else begin
      m_errp = 0;
      if (bus.valid) begin
        f  = int'((bus.data_in >> LSB) & 32'(MODV - 1));
        fl = bus.data_in[0];
        if (m_started) begin
          if (fl && !m_prev && m_rises < EMAX) m_rises++;
          if (m_locked) begin
            if (f != m_exp) begin
              m_errp = 1;
              if (m_err < EMAX) m_err++;
              m_locked = 0;
              m_streak = 0;
            end
          end else if (f == m_exp) begin
            m_streak++;
            if (m_streak == LC) begin
              m_locked = 1;
              m_streak = 0;
            end
          end else begin
            m_streak = 0;
          end
        end
        m_started = 1;
        m_exp  = (f + 1) % MODV;
        m_last = f;
        m_prev = fl;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("locked",     bus.locked,     m_locked);
      check("err_pulse",  bus.err_pulse,  m_errp);
      check("err_count",  bus.err_count,  m_err);
      check("flag_rises", bus.flag_rises, m_rises);
      check("last_cnt",   bus.last_cnt,   m_last);
      if (bus.err_pulse) pulses++;
    end
  end

  task automatic send(input bit v, input int c, input bit fl);
    logic [31:0] d;
    @(negedge clk);
    d = $urandom();
    d[LSB +: CW] = CW'(c);
    d[0] = fl;
    bus.data_in = d;
    bus.valid   = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int c;
    bus.valid   = 1'b0;
    bus.data_in = '0;
    #1 rst = 1'b1;
    #1;
    check("reset_locked",   bus.locked,     0);
    check("reset_err",      bus.err_count,  0);
    check("reset_last_cnt", bus.last_cnt,   0);
    check("reset_rises",    bus.flag_rises, 0);
    @(negedge clk);
    rst = 1'b0;

    // Lock-on from a clean start: four matches after the reference sample.
    for (int i = 0; i < 6; i++) begin
      send(1, i, 0);
      if (i == 3) check("lock_not_yet", bus.locked, 0);
      if (i == 4) check("lock_after_5th", bus.locked, 1);
    end
    check("lock_err0",  bus.err_count, 0);
    check("lock_last5", bus.last_cnt,  5);

    // Break in the sequence while locked, then relock.
    send(1, 6, 0); send(1, 7, 0); send(1, 8, 0);
    send(1, 12, 0);
    check("brk_pulse",  bus.err_pulse, 1);
    check("brk_err1",   bus.err_count, 1);
    check("brk_unlock", bus.locked,    0);
    send(1, 13, 0);
    check("brk_pulse_1cyc", bus.err_pulse, 0);
    send(1, 14, 0); send(1, 15, 0);
    check("relock_not_yet", bus.locked, 0);
    send(1, 16, 0);
    check("relock", bus.locked, 1);

    // valid low: everything holds regardless of data_in.
    for (int i = 0; i < 5; i++) send(0, int'($urandom_range(0, MODV - 1)), 1'($urandom_range(0, 1)));
    check("hold_locked", bus.locked,    1);
    check("hold_last",   bus.last_cnt,  16);
    check("hold_err",    bus.err_count, 1);

    // Wrap-around is a match.
    do_reset();
    for (int i = 1017; i <= 1021; i++) send(1, i, 0);
    check("wrap_locked", bus.locked, 1);
    pulses = 0;
    send(1, 1022, 0); send(1, 1023, 0); send(1, 0, 0); send(1, 1, 0);
    check("wrap_still_locked", bus.locked,    1);
    check("wrap_err0",         bus.err_count, 0);
    check("wrap_no_pulse",     pulses,        0);
    check("wrap_last",         bus.last_cnt,  1);

    // Flag edges: the reference sample's flag is never counted as an edge.
    do_reset();
    send(1, 0, 1);
    check("flag_first_ignored", bus.flag_rises, 0);
    send(1, 1, 0); send(1, 2, 1); send(1, 3, 0); send(1, 4, 1); send(1, 5, 1);
    check("flag_rises2", bus.flag_rises, 2);

    // Accumulate three errors, then reset asynchronously between edges.
    do_reset();
    for (int i = 0; i < 5; i++) send(1, i, 0);
    c = 4;
    for (int k = 0; k < 3; k++) begin
      c = (c + 100) % MODV;
      send(1, c, 0);
      for (int j = 0; j < LC; j++) begin
        c = (c + 1) % MODV;
        send(1, c, 0);
      end
    end
    check("pre_rst_err3",    bus.err_count, 3);
    check("pre_rst_locked",  bus.locked,    1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_locked", bus.locked,     0);
    check("async_err",    bus.err_count,  0);
    check("async_pulse",  bus.err_pulse,  0);
    check("async_rises",  bus.flag_rises, 0);
    check("async_last",   bus.last_cnt,   0);
    @(negedge clk);
    rst = 1'b0;
    send(1, 500, 0);
    check("post_rst_pulse", bus.err_pulse, 0);
    check("post_rst_last",  bus.last_cnt,  500);
    send(1, 77, 0);
    check("seek_no_err", bus.err_count, 0);

    // Random stream: mostly incrementing, occasional jumps, gaps and flag toggles.
    do_reset();
    c = 1000;
    for (int n = 0; n < 3000; n++) begin
      bit v;
      int r;
      v = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 24));
      if (r == 0)   c = int'($urandom_range(0, MODV - 1));
      else if (v)   c = (c + 1) % MODV;
      send(v, c, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    bus.valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
